// File: rtl/regfile_mp_if.sv
// Read, write and claim signal bundle for regfile_mp.
// The register file takes the slave modport; whoever drives it takes the master modport.
interface regfile_mp_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*AW-1:0]     wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     claim_en;
   logic [AW-1:0]            claim_addr;
   logic                     ready;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  rd_data, rd_busy, ready
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output rd_data, rd_busy, ready
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-destination scoreboard.
// A sequential INIT sweep fills the array after reset; the ports become live in RUN.
module regfile_mp #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 32,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter int INIT_MODE = 1,
   parameter int ZERO_R0   = 1,
   parameter int BYPASS    = 1
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [0:0]    ST_INIT  = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

   logic [0:0]          state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;
   logic                run;

   assign run       = (state_q == ST_RUN);
   assign bus.ready = run;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (!run) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
         end
      end
   end

   // Per-register next state; ascending port order makes the highest write port win,
   // and the claim is applied after the write clears so a same-cycle claim wins.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [AW-1:0] MY_ADDR   = AW'(gi);
      localparam bit            HARD_ZERO = (ZERO_R0 != 0) && (gi == 0);
      logic [DATA_W-1:0] reg_nx;
      logic              pend_nx;

      always_comb begin
         reg_nx  = regs_q[gi];
         pend_nx = pend_q[gi];
         if (!run) begin
            if (idx_q == MY_ADDR) begin
               reg_nx = (INIT_MODE != 0) ? DATA_W'(gi) : '0;
            end
         end else if (!HARD_ZERO) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == MY_ADDR)) begin
                  reg_nx  = bus.wr_data[j*DATA_W +: DATA_W];
                  pend_nx = 1'b0;
               end
            end
            if (bus.claim_en && (bus.claim_addr == MY_ADDR)) begin
               pend_nx = 1'b1;
            end
         end
      end

      assign regs_d[gi] = reg_nx;
      assign pend_d[gi] = pend_nx;
   end

   // Reset restarts the sweep and clears the scoreboard but leaves the array contents alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     addr;
      logic              in_range;
      logic [DATA_W-1:0] data_c;

      assign addr     = bus.rd_addr[gi*AW +: AW];
      assign in_range = (32'(addr) < NUM_REGS);

      always_comb begin
         data_c = '0;
         if (run && in_range && !((ZERO_R0 != 0) && (addr == '0))) begin
            data_c = regs_q[addr];
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == addr)) begin
                     data_c = bus.wr_data[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = data_c;
      assign bus.rd_busy[gi]                  = run && in_range && pend_q[addr];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a small no-bypass instance, checked each
// cycle against a behavioural model plus directed literal expectations.
module tb_regfile_mp;
   localparam int A_DW = 32, A_N = 32, A_RD = 2, A_WR = 2, A_AW = 5;
   localparam int B_DW = 8,  B_N = 16, B_RD = 3, B_WR = 2, B_AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(A_DW), .NUM_REGS(A_N), .NUM_RD(A_RD), .NUM_WR(A_WR)) bus_a ();
   regfile_mp_if #(.DATA_W(B_DW), .NUM_REGS(B_N), .NUM_RD(B_RD), .NUM_WR(B_WR)) bus_b ();

   regfile_mp #(.DATA_W(A_DW), .NUM_REGS(A_N), .NUM_RD(A_RD), .NUM_WR(A_WR),
                .INIT_MODE(1), .ZERO_R0(1), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   regfile_mp #(.DATA_W(B_DW), .NUM_REGS(B_N), .NUM_RD(B_RD), .NUM_WR(B_WR),
                .INIT_MODE(1), .ZERO_R0(1), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_mem  [2][32];
   bit          m_pend [2][32];
   bit          m_ready[2];
   int          m_cnt  [2];

   bit          cur_wen[2][2];
   int unsigned cur_wa [2][2];
   int unsigned cur_wd [2][2];
   bit          cur_ce [2];
   int unsigned cur_ca [2];
   int unsigned cur_ra [2][3];

   always_comb begin
      for (int j = 0; j < 2; j++) begin
         cur_wen[0][j] = bus_a.wr_en[j];
         cur_wa[0][j]  = 32'(bus_a.wr_addr[j*A_AW +: A_AW]);
         cur_wd[0][j]  = 32'(bus_a.wr_data[j*A_DW +: A_DW]);
         cur_wen[1][j] = bus_b.wr_en[j];
         cur_wa[1][j]  = 32'(bus_b.wr_addr[j*B_AW +: B_AW]);
         cur_wd[1][j]  = 32'(bus_b.wr_data[j*B_DW +: B_DW]);
      end
      cur_ce[0] = bus_a.claim_en;
      cur_ca[0] = 32'(bus_a.claim_addr);
      cur_ce[1] = bus_b.claim_en;
      cur_ca[1] = 32'(bus_b.claim_addr);
      cur_ra[0][0] = 32'(bus_a.rd_addr[0 +: A_AW]);
      cur_ra[0][1] = 32'(bus_a.rd_addr[A_AW +: A_AW]);
      cur_ra[0][2] = 0;
      for (int k = 0; k < 3; k++) begin
         cur_ra[1][k] = 32'(bus_b.rd_addr[k*B_AW +: B_AW]);
      end
   end

   task automatic model_step(input int inst, input int n);
      if (rst) begin
         m_ready[inst] = 1'b0;
         m_cnt[inst]   = 0;
         for (int i = 0; i < 32; i++) m_pend[inst][i] = 1'b0;
      end else if (!m_ready[inst]) begin
         m_cnt[inst]++;
         if (m_cnt[inst] == n) begin
            m_ready[inst] = 1'b1;
            for (int i = 0; i < n; i++) m_mem[inst][i] = i;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (cur_wen[inst][j] && cur_wa[inst][j] < n && cur_wa[inst][j] != 0) begin
               m_mem[inst][cur_wa[inst][j]]  = cur_wd[inst][j];
               m_pend[inst][cur_wa[inst][j]] = 1'b0;
            end
         end
         if (cur_ce[inst] && cur_ca[inst] < n && cur_ca[inst] != 0)
            m_pend[inst][cur_ca[inst]] = 1'b1;
      end
   endtask

   function automatic int unsigned exp_rd(input int inst, input int n, input bit byp,
                                          input int unsigned addr);
      int unsigned v;
      if (!m_ready[inst] || addr >= n || addr == 0) return 0;
      v = m_mem[inst][addr];
      if (byp)
         for (int j = 0; j < 2; j++)
            if (cur_wen[inst][j] && cur_wa[inst][j] == addr) v = cur_wd[inst][j];
      return v;
   endfunction

   function automatic bit exp_busy(input int inst, input int n, input int unsigned addr);
      return m_ready[inst] && addr < n && m_pend[inst][addr];
   endfunction

   always @(posedge clk) begin
      model_step(0, A_N);
      model_step(1, B_N);
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int k = 0; k < A_RD; k++) begin
            check($sformatf("A_rd_data%0d", k), 64'(bus_a.rd_data[k*A_DW +: A_DW]),
                  64'(exp_rd(0, A_N, 1'b1, cur_ra[0][k])));
            check($sformatf("A_rd_busy%0d", k), 64'(bus_a.rd_busy[k]),
                  64'(exp_busy(0, A_N, cur_ra[0][k])));
         end
         check("A_ready", 64'(bus_a.ready), 64'(m_ready[0]));
         for (int k = 0; k < B_RD; k++) begin
            check($sformatf("B_rd_data%0d", k), 64'(bus_b.rd_data[k*B_DW +: B_DW]),
                  64'(exp_rd(1, B_N, 1'b0, cur_ra[1][k])));
            check($sformatf("B_rd_busy%0d", k), 64'(bus_b.rd_busy[k]),
                  64'(exp_busy(1, B_N, cur_ra[1][k])));
         end
         check("B_ready", 64'(bus_b.ready), 64'(m_ready[1]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.claim_en = 1'b0; bus_a.claim_addr = '0;
      bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.claim_en = 1'b0; bus_b.claim_addr = '0;
   endtask

   task automatic wr_a(input int j, input bit en, input int unsigned addr, input int unsigned data);
      bus_a.wr_en[j] = en;
      bus_a.wr_addr[j*A_AW +: A_AW] = A_AW'(addr);
      bus_a.wr_data[j*A_DW +: A_DW] = A_DW'(data);
   endtask

   task automatic wr_b(input int j, input bit en, input int unsigned addr, input int unsigned data);
      bus_b.wr_en[j] = en;
      bus_b.wr_addr[j*B_AW +: B_AW] = B_AW'(addr);
      bus_b.wr_data[j*B_DW +: B_DW] = B_DW'(data);
   endtask

   task automatic rd_a(input int k, input int unsigned addr);
      bus_a.rd_addr[k*A_AW +: A_AW] = A_AW'(addr);
   endtask

   task automatic rd_b(input int k, input int unsigned addr);
      bus_b.rd_addr[k*B_AW +: B_AW] = B_AW'(addr);
   endtask

   function automatic logic [31:0] da(input int k);
      return bus_a.rd_data[k*A_DW +: A_DW];
   endfunction

   function automatic logic [7:0] db(input int k);
      return bus_b.rd_data[k*B_DW +: B_DW];
   endfunction

   // Drops rst (already sampled high) and counts edges until each instance reports ready.
   task automatic release_and_count(output int ca, output int cb);
      ca = 0;
      cb = 0;
      rst = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (cb == 0 && bus_b.ready) cb = c;
         if (bus_a.ready) begin
            ca = c;
            break;
         end
      end
   endtask

   int ca, cb;

   initial begin
      idle();
      bus_a.rd_addr = '0;
      bus_b.rd_addr = '0;
      rst = 1'b1;
      tick();
      cmp_on = 1'b1;
      tick();
      check("lit_ready_in_rst", 64'(bus_a.ready), 64'd0);

      release_and_count(ca, cb);
      check("lit_A_ready_latency", 64'(ca), 64'd32);
      check("lit_B_ready_latency", 64'(cb), 64'd16);

      rd_a(0, 5); rd_a(1, 0);
      #1;
      check("lit_reg5", 64'(da(0)), 64'd5);
      check("lit_reg0", 64'(da(1)), 64'd0);

      // two writers on one address: port 1 wins, visible through bypass and after the edge
      wr_a(0, 1'b1, 3, 32'hAAAA); wr_a(1, 1'b1, 3, 32'h5555); rd_a(0, 3);
      #1;
      check("lit_bypass_prio", 64'(da(0)), 64'h5555);
      tick();
      idle();
      #1;
      check("lit_after_prio", 64'(da(0)), 64'h5555);

      bus_a.claim_en = 1'b1; bus_a.claim_addr = 5'd7; rd_a(1, 7);
      #1;
      check("lit_claim_no_bypass", 64'(bus_a.rd_busy[1]), 64'd0);
      tick();
      idle();
      #1;
      check("lit_claim_busy", 64'(bus_a.rd_busy[1]), 64'd1);
      wr_a(0, 1'b1, 7, 32'h77);
      tick();
      idle();
      #1;
      check("lit_write_clears", 64'(bus_a.rd_busy[1]), 64'd0);
      check("lit_write_data", 64'(da(1)), 64'h77);
      bus_a.claim_en = 1'b1; bus_a.claim_addr = 5'd7; wr_a(1, 1'b1, 7, 32'h99);
      tick();
      idle();
      #1;
      check("lit_claim_wins", 64'(bus_a.rd_busy[1]), 64'd1);
      check("lit_claim_wins_data", 64'(da(1)), 64'h99);

      wr_a(0, 1'b1, 0, 32'hFFFF); bus_a.claim_en = 1'b1; bus_a.claim_addr = '0;
      rd_a(0, 0); rd_a(1, 0);
      #1;
      check("lit_r0_bypass", 64'(da(0)), 64'd0);
      check("lit_r0_busy", 64'(bus_a.rd_busy[0]), 64'd0);
      tick();
      idle();
      #1;
      check("lit_r0_after", 64'(da(0)), 64'd0);
      check("lit_r0_busy_after", 64'(bus_a.rd_busy[1]), 64'd0);

      // no-bypass instance: write appears only after the edge, three ports independent
      wr_b(0, 1'b1, 5, 8'h3C); rd_b(0, 5); rd_b(1, 1); rd_b(2, 2);
      #1;
      check("lit_B_no_bypass", 64'(db(0)), 64'd5);
      check("lit_B_port1", 64'(db(1)), 64'd1);
      check("lit_B_port2", 64'(db(2)), 64'd2);
      tick();
      idle();
      #1;
      check("lit_B_after", 64'(db(0)), 64'h3C);
      wr_b(0, 1'b1, 9, 8'h5A); wr_b(1, 1'b1, 9, 8'hA5); rd_b(2, 9);
      #1;
      check("lit_B_old9", 64'(db(2)), 64'd9);
      tick();
      idle();
      #1;
      check("lit_B_prio9", 64'(db(2)), 64'hA5);

      // reset in the middle of INIT restarts the full sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      release_and_count(ca, cb);
      check("lit_mid_init_latency", 64'(ca), 64'd32);

      wr_a(0, 1'b1, 4, 32'h1234); bus_a.claim_en = 1'b1; bus_a.claim_addr = 5'd9;
      tick();
      idle();
      rd_a(0, 4); rd_a(1, 9);
      #1;
      check("lit_reg4_written", 64'(da(0)), 64'h1234);
      check("lit_reg9_busy", 64'(bus_a.rd_busy[1]), 64'd1);
      rst = 1'b1;
      tick();
      check("lit_ready_drop", 64'(bus_a.ready), 64'd0);
      check("lit_busy_cleared", 64'(bus_a.rd_busy[1]), 64'd0);
      release_and_count(ca, cb);
      check("lit_run_reset_latency", 64'(ca), 64'd32);
      #1;
      check("lit_reg4_reinit", 64'(da(0)), 64'd4);
      check("lit_reg9_not_busy", 64'(bus_a.rd_busy[1]), 64'd0);

      // mixed traffic on a narrow address window to force collisions, with rare resets
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < 2; j++) begin
            wr_a(j, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
            wr_b(j, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
         end
         bus_a.claim_en = 1'($urandom_range(0, 1)); bus_a.claim_addr = 5'($urandom_range(0, 7));
         bus_b.claim_en = 1'($urandom_range(0, 1)); bus_b.claim_addr = 4'($urandom_range(0, 15));
         for (int k = 0; k < A_RD; k++) rd_a(k, $urandom_range(0, 7));
         for (int k = 0; k < B_RD; k++) rd_b(k, $urandom_range(0, 15));
         rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
